plc_scan_sequencer: RTL and testbench

PLC_SCAN_SEQUENCER -- requirements
Module: plc_scan_sequencer

---
 rtl/plc_scan_sequencer.sv | 138 +++++++++++++
 tb/tb_plc_scan_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module : plc_scan_sequencer
// Brief  : PLC scan-cycle sequencer: input snapshot, rung dispatch, output
//          commit and per-rung watchdog.
// Rev    : 1.0  initial release
// ============================================================================
module plc_scan_sequencer #(
    parameter int NUM_RUNGS = 16,
    parameter int IN_W      = 19,
    parameter int OUT_W     = 19,
    parameter int WD_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic [IN_W-1:0]  raw_in,
    input  logic             rung_done,
    input  logic [OUT_W-1:0] eval_out,
    output logic [IN_W-1:0]  in_image,
    output logic [7:0]       rung_idx,
    output logic             rung_req,
    output logic [OUT_W-1:0] out_image,
    output logic             scan_done,
    output logic [15:0]      scan_count,
    output logic             wd_fault
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_COMMIT = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [7:0]  c_last_rung = 8'(NUM_RUNGS - 1);
    localparam logic [15:0] c_wd_limit  = 16'(WD_CYCLES);

    state_t           r_state;
    state_t           w_state_next;
    logic [IN_W-1:0]  r_in_image;
    logic [7:0]       r_rung_idx;
    logic [OUT_W-1:0] r_out_image;
    logic             r_scan_done;
    logic [15:0]      r_scan_count;
    logic             r_wd_fault;
    logic [15:0]      r_wd_cnt;
    logic [15:0]      w_wd_next;
    logic             w_last_rung;

    always_comb begin
        w_state_next = r_state;
        w_wd_next    = r_wd_cnt + 16'd1;
        w_last_rung  = (r_rung_idx == c_last_rung);
        case (r_state)
            S_IDLE: begin
                if (run || step) begin
                    w_state_next = S_LATCH;
                end
            end
            S_LATCH:  w_state_next = S_ISSUE;
            S_ISSUE:  w_state_next = S_WAIT;
            S_WAIT: begin
                if (rung_done) begin
                    w_state_next = w_last_rung ? S_COMMIT : S_ISSUE;
                end else if (w_wd_next >= c_wd_limit) begin
                    w_state_next = S_FAULT;
                end
            end
            S_COMMIT: w_state_next = run ? S_LATCH : S_IDLE;
            S_FAULT:  w_state_next = S_FAULT;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_in_image   <= '0;
            r_rung_idx   <= '0;
            r_out_image  <= '0;
            r_scan_done  <= 1'b0;
            r_scan_count <= '0;
            r_wd_fault   <= 1'b0;
            r_wd_cnt     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_scan_done <= 1'b0;
            case (r_state)
                S_LATCH: begin
                    r_in_image <= raw_in;
                    r_rung_idx <= '0;
                end
                S_ISSUE: begin
                    r_wd_cnt <= '0;
                end
                S_WAIT: begin
                    if (rung_done) begin
                        if (!w_last_rung) begin
                            r_rung_idx <= r_rung_idx + 8'd1;
                        end
                    end else begin
                        r_wd_cnt <= w_wd_next;
                        // Outputs drop on the same edge the watchdog trips.
                        if (w_state_next == S_FAULT) begin
                            r_out_image <= '0;
                            r_wd_fault  <= 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    r_out_image  <= eval_out;
                    r_scan_done  <= 1'b1;
                    r_scan_count <= r_scan_count + 16'd1;
                end
                S_FAULT: begin
                    r_out_image <= '0;
                    r_wd_fault  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_image   = r_in_image;
    assign rung_idx   = r_rung_idx;
    assign rung_req   = (r_state == S_ISSUE);
    assign out_image  = r_out_image;
    assign scan_done  = r_scan_done;
    assign scan_count = r_scan_count;
    assign wd_fault   = r_wd_fault;

endmodule
`default_nettype wire

// File: tb/tb_plc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_plc_scan_sequencer
// Brief  : Self-checking bench for plc_scan_sequencer (4 rungs, watchdog 8).
// Rev    : 1.0  initial release
// ============================================================================
module tb_plc_scan_sequencer;

    localparam int NR = 4;
    localparam int WD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [18:0] raw_in = '0;
    logic        rung_done = 1'b0;
    logic [18:0] eval_out = '0;
    logic [18:0] in_image;
    logic [7:0]  rung_idx;
    logic        rung_req;
    logic [18:0] out_image;
    logic        scan_done;
    logic [15:0] scan_count;
    logic        wd_fault;

    plc_scan_sequencer #(
        .NUM_RUNGS (NR),
        .IN_W      (19),
        .OUT_W     (19),
        .WD_CYCLES (WD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step       (step),
        .raw_in     (raw_in),
        .rung_done  (rung_done),
        .eval_out   (eval_out),
        .in_image   (in_image),
        .rung_idx   (rung_idx),
        .rung_req   (rung_req),
        .out_image  (out_image),
        .scan_done  (scan_done),
        .scan_count (scan_count),
        .wd_fault   (wd_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        step;
        logic        done;
        logic [18:0] raw;
        logic [18:0] ev;
        logic        req;
        logic [7:0]  idx;
        logic        sd;
        logic [18:0] out;
        logic [15:0] cnt;
        logic [18:0] img;
        logic        fault;
    } vec_t;

    vec_t tbl [22];

    int   n_checks = 0;
    int   n_pass = 0;
    int   sd_count = 0;
    int   req_count = 0;
    logic auto_resp = 1'b0;
    logic last_req = 1'b0;

    // random-phase reference model state
    int          exp_idx, sum_d, k0, pend_left, scans, d;
    logic        pend, prev_req, in_scan;
    logic [18:0] snap, exp_out;
    logic [15:0] exp_cnt;

    function automatic vec_t mk(input logic r, input logic s, input logic dn,
                                input logic [18:0] raw, input logic [18:0] ev,
                                input logic q, input logic [7:0] ix, input logic sd,
                                input logic [18:0] o, input logic [15:0] c,
                                input logic [18:0] im, input logic f);
        vec_t v;
        v.run = r; v.step = s; v.done = dn; v.raw = raw; v.ev = ev;
        v.req = q; v.idx = ix; v.sd = sd; v.out = o; v.cnt = c; v.img = im; v.fault = f;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    endtask

    task automatic tick();
        @(negedge clk);
        if (scan_done) sd_count++;
        if (rung_req) req_count++;
        if (auto_resp) rung_done = last_req;
        last_req = rung_req;
    endtask

    task automatic reset_dut();
        rst = 1'b1; run = 1'b0; step = 1'b0; rung_done = 1'b0;
        auto_resp = 1'b0; last_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_req(input logic [7:0] idx);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (rung_req && rung_idx == idx) found = 1'b1;
        end
        check($sformatf("wait_req_%0d", idx), 64'(found), 64'(1));
    endtask

    task automatic wait_scan_done();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (scan_done) found = 1'b1;
        end
        check("wait_scan_done", 64'(found), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Two scans, one-cycle rung_done, raw_in changing during rung 1,
        // run dropped in the second COMMIT cycle.
        tbl[0]  = mk(1,0,0,19'h00001,19'h000A5, 0,0,0,19'h0,    0,19'h00001,0);
        tbl[0].img = 19'h0;
        tbl[1]  = mk(1,0,0,19'h00001,19'h000A5, 1,0,0,19'h0,    0,19'h00001,0);
        tbl[2]  = mk(1,0,0,19'h00001,19'h000A5, 0,0,0,19'h0,    0,19'h00001,0);
        tbl[3]  = mk(1,0,1,19'h00001,19'h000A5, 1,1,0,19'h0,    0,19'h00001,0);
        tbl[4]  = mk(1,0,0,19'h40000,19'h000A5, 0,1,0,19'h0,    0,19'h00001,0);
        tbl[5]  = mk(1,0,1,19'h40000,19'h000A5, 1,2,0,19'h0,    0,19'h00001,0);
        tbl[6]  = mk(1,0,0,19'h40000,19'h000A5, 0,2,0,19'h0,    0,19'h00001,0);
        tbl[7]  = mk(1,0,1,19'h40000,19'h000A5, 1,3,0,19'h0,    0,19'h00001,0);
        tbl[8]  = mk(1,0,0,19'h40000,19'h000A5, 0,3,0,19'h0,    0,19'h00001,0);
        tbl[9]  = mk(1,0,1,19'h40000,19'h000A5, 0,3,0,19'h0,    0,19'h00001,0);
        tbl[10] = mk(1,0,0,19'h40000,19'h000A5, 0,3,1,19'h000A5,1,19'h00001,0);
        tbl[11] = mk(1,0,0,19'h40000,19'h000A5, 1,0,0,19'h000A5,1,19'h40000,0);
        tbl[12] = mk(1,0,0,19'h40000,19'h12345, 0,0,0,19'h000A5,1,19'h40000,0);
        tbl[13] = mk(1,0,1,19'h40000,19'h12345, 1,1,0,19'h000A5,1,19'h40000,0);
        tbl[14] = mk(1,0,0,19'h40000,19'h12345, 0,1,0,19'h000A5,1,19'h40000,0);
        tbl[15] = mk(1,0,1,19'h40000,19'h12345, 1,2,0,19'h000A5,1,19'h40000,0);
        tbl[16] = mk(1,0,0,19'h40000,19'h12345, 0,2,0,19'h000A5,1,19'h40000,0);
        tbl[17] = mk(1,0,1,19'h40000,19'h12345, 1,3,0,19'h000A5,1,19'h40000,0);
        tbl[18] = mk(1,0,0,19'h40000,19'h12345, 0,3,0,19'h000A5,1,19'h40000,0);
        tbl[19] = mk(1,0,1,19'h40000,19'h12345, 0,3,0,19'h000A5,1,19'h40000,0);
        tbl[20] = mk(0,0,0,19'h40000,19'h12345, 0,3,1,19'h12345,2,19'h40000,0);
        tbl[21] = mk(0,0,0,19'h40000,19'h12345, 0,3,0,19'h12345,2,19'h40000,0);

        raw_in = 19'h7FFFF;
        reset_dut();
        check("reset_ctl", 64'({rung_idx, rung_req, scan_done, scan_count, wd_fault}), 64'(0));
        check("reset_data", 64'({in_image, out_image}), 64'(0));

        for (int i = 0; i < 22; i++) begin
            run = tbl[i].run; step = tbl[i].step; rung_done = tbl[i].done;
            raw_in = tbl[i].raw; eval_out = tbl[i].ev;
            @(negedge clk);
            check($sformatf("tbl_ctl_%0d", i),
                  64'({rung_req, rung_idx, scan_done, scan_count, wd_fault}),
                  64'({tbl[i].req, tbl[i].idx, tbl[i].sd, tbl[i].cnt, tbl[i].fault}));
            check($sformatf("tbl_data_%0d", i), 64'({out_image, in_image}),
                  64'({tbl[i].out, tbl[i].img}));
        end

        // Watchdog: a good scan first so the forced clear of out_image is visible.
        reset_dut();
        eval_out = 19'h000A5; run = 1'b1; auto_resp = 1'b1;
        wait_scan_done();
        auto_resp = 1'b0; rung_done = 1'b0;
        repeat (9) tick();
        check("wd_not_early", 64'(wd_fault), 64'(0));
        tick();
        check("wd_trip", 64'({wd_fault, rung_req, out_image}), 64'({1'b1, 1'b0, 19'h0}));
        for (int i = 0; i < 20; i++) begin
            run = 1'b1; step = 1'($urandom); rung_done = 1'($urandom);
            tick();
            check("fault_hold", 64'({wd_fault, rung_req, scan_done, out_image}),
                  64'({1'b1, 1'b0, 1'b0, 19'h0}));
        end
        reset_dut();
        check("fault_cleared", 64'({wd_fault, out_image}), 64'(0));

        // run dropped during rung 2: the scan still commits, then idle.
        reset_dut();
        eval_out = 19'h00F0F; run = 1'b1; auto_resp = 1'b1;
        wait_req(8'd2);
        run = 1'b0; sd_count = 0;
        repeat (40) tick();
        check("rundrop_scans", 64'(sd_count), 64'(1));
        check("rundrop_count", 64'({scan_count, out_image}), 64'({16'd1, 19'h00F0F}));
        req_count = 0;
        repeat (10) tick();
        check("rundrop_idle_req", 64'(req_count), 64'(0));

        // step pulsed, then again mid-scan: exactly one scan.
        reset_dut();
        sd_count = 0; auto_resp = 1'b1;
        step = 1'b1; tick(); step = 1'b0;
        wait_req(8'd1);
        step = 1'b1; repeat (2) tick(); step = 1'b0;
        repeat (40) tick();
        check("step_scans", 64'(sd_count), 64'(1));
        check("step_count", 64'(scan_count), 64'(1));

        // rst during rung 3 aborts the scan with no commit.
        reset_dut();
        raw_in = 19'h5A5A5; eval_out = 19'h3C3C3; run = 1'b1; auto_resp = 1'b1;
        wait_req(8'd3);
        tick();
        rst = 1'b1; sd_count = 0;
        tick();
        check("rst_mid_ctl", 64'({rung_idx, rung_req, scan_done, scan_count, wd_fault}), 64'(0));
        check("rst_mid_data", 64'({in_image, out_image}), 64'(0));
        rst = 1'b0; run = 1'b0;
        repeat (20) tick();
        check("rst_mid_no_scan", 64'({sd_count, 16'(scan_count)}), 64'(0));

        // Randomized back-to-back scans against a latency/snapshot model.
        reset_dut();
        run = 1'b1;
        exp_idx = 0; sum_d = 0; k0 = 0; pend_left = 0; scans = 0;
        pend = 1'b0; prev_req = 1'b0; in_scan = 1'b0; snap = '0; exp_out = '0; exp_cnt = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (pend) begin
                if (pend_left == 0) begin
                    rung_done = 1'b1;
                    pend = 1'b0;
                end else begin
                    rung_done = 1'b0;
                    pend_left--;
                end
            end else begin
                rung_done = ($urandom_range(0, 3) == 0);
            end
            if (rung_req) begin
                check("rand_req_width", 64'({prev_req, rung_req}), 64'(2'b01));
                check("rand_idx", 64'(rung_idx), 64'(exp_idx));
                if (exp_idx == 0) begin
                    k0 = c; sum_d = 0; snap = raw_in; in_scan = 1'b1;
                    eval_out = 19'($urandom);
                    exp_out = eval_out;
                end
                d = $urandom_range(0, 5);
                sum_d += d;
                pend = 1'b1;
                pend_left = d;
                exp_idx = (exp_idx + 1) % NR;
            end
            if (in_scan) check("rand_in_image", 64'(in_image), 64'(snap));
            if (scan_done) begin
                exp_cnt++;
                scans++;
                check("rand_latency", 64'(c), 64'(k0 + 2 * NR + sum_d + 1));
                check("rand_commit", 64'({scan_count, out_image, wd_fault}),
                      64'({exp_cnt, exp_out, 1'b0}));
            end
            prev_req = rung_req;
            raw_in = 19'($urandom);
        end
        check("rand_scan_total", 64'(scans >= 60), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
